ef_pin_mux_ctrl: RTL and testbench



---
 rtl/ef_pin_mux_ctrl_if.sv | 23 ++
 rtl/ef_pin_mux_ctrl.sv | 137 +++++++++++++
 tb/tb_ef_pin_mux_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/ef_pin_mux_ctrl_if.sv
// Software-side staging/commit bus of the pin-mux selection controller.
// Master drives writes and commits; slave reports sequence status.
interface ef_pin_mux_ctrl_if #(
    parameter int COUNT = 32
);
    logic             wr_en;
    logic [COUNT-1:0] wr_sel0;
    logic [COUNT-1:0] wr_sel1;
    logic             commit;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output wr_en, wr_sel0, wr_sel1, commit,
        input  busy, done, err
    );

    modport slave (
        input  wr_en, wr_sel0, wr_sel1, commit,
        output busy, done, err
    );
endinterface

// File: rtl/ef_pin_mux_ctrl.sv
// Glitch-free pin-mux selection controller: shadow registers plus a
// commit sequencer that tristates changing pins around the switch.
module ef_pin_mux_ctrl #(
    parameter int               COUNT        = 32,
    parameter int               GUARD_CYCLES = 4,
    parameter logic [COUNT-1:0] RESET_SEL0   = {COUNT{1'b0}},
    parameter logic [COUNT-1:0] RESET_SEL1   = {COUNT{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    ef_pin_mux_ctrl_if.slave bus,
    output logic [COUNT-1:0] sel0,
    output logic [COUNT-1:0] sel1,
    input  logic [COUNT-1:0] mux_oeb,
    output logic [COUNT-1:0] pad_oeb
);
    localparam int CW = $clog2(GUARD_CYCLES + 1);
    localparam logic [CW-1:0] LOAD = CW'(GUARD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, OFF, SWITCH, SETTLE} state_t;

    state_t           state, nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [COUNT-1:0] sh0, sh1, tgt0, tgt1, chg;
    logic [COUNT-1:0] sh0_new, sh1_new, chg_new;
    logic [COUNT-1:0] force_mask, force_d;
    logic             busy_q, done_q, err_q;
    logic             busy_d, done_d, err_d;
    logic             last;

    // A write in the commit cycle is seen by that commit.
    assign sh0_new = bus.wr_en ? bus.wr_sel0 : sh0;
    assign sh1_new = bus.wr_en ? bus.wr_sel1 : sh1;
    assign chg_new = (sh0_new ^ sel0) | (sh1_new ^ sel1);
    assign last    = (cnt == '0);

    assign pad_oeb  = mux_oeb | force_mask;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;

    // State, guard counter and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            force_mask <= '0;
        end else begin
            state      <= nxt;
            cnt        <= cnt_nxt;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            force_mask <= force_d;
        end
    end

    // Next state; the counter reloads on every state entry.
    always_comb begin
        nxt     = state;
        cnt_nxt = cnt;
        unique case (state)
            IDLE: begin
                if (bus.commit && |chg_new) begin
                    nxt     = OFF;
                    cnt_nxt = LOAD;
                end
            end
            OFF: begin
                if (last) begin
                    nxt     = SWITCH;
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            SWITCH: begin
                nxt     = SETTLE;
                cnt_nxt = LOAD;
            end
            SETTLE: begin
                if (last) begin
                    nxt     = IDLE;
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: begin
                nxt     = IDLE;
                cnt_nxt = '0;
            end
        endcase
    end

    // Output next-values, registered alongside the state.
    always_comb begin
        busy_d  = (nxt != IDLE);
        force_d = '0;
        if (nxt != IDLE) begin
            force_d = (state == IDLE) ? chg_new : chg;
        end
        done_d = ((state == SETTLE) && (nxt == IDLE)) ||
                 ((state == IDLE) && bus.commit && ~|chg_new);
        err_d  = bus.commit && (state != IDLE);
    end

    // Shadow, commit snapshot and active selection registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh0  <= RESET_SEL0;
            sh1  <= RESET_SEL1;
            tgt0 <= RESET_SEL0;
            tgt1 <= RESET_SEL1;
            chg  <= '0;
            sel0 <= RESET_SEL0;
            sel1 <= RESET_SEL1;
        end else begin
            if (bus.wr_en) begin
                sh0 <= bus.wr_sel0;
                sh1 <= bus.wr_sel1;
            end
            if ((state == IDLE) && bus.commit) begin
                tgt0 <= sh0_new;
                tgt1 <= sh1_new;
                chg  <= chg_new;
            end
            if (state == SWITCH) begin
                sel0 <= tgt0;
                sel1 <= tgt1;
            end
        end
    end
endmodule

// File: tb/tb_ef_pin_mux_ctrl.sv
// Directed bench for ef_pin_mux_ctrl with COUNT=4, GUARD_CYCLES=2.
// Expected values are hand-computed per vector.
module tb_ef_pin_mux_ctrl;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] sel0, sel1, mux_oeb, pad_oeb;
    int           checks = 0;
    int           failures = 0;
    int           ndone;

    ef_pin_mux_ctrl_if #(.COUNT(N)) bus ();

    ef_pin_mux_ctrl #(
        .COUNT(N),
        .GUARD_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .sel0(sel0),
        .sel1(sel1),
        .mux_oeb(mux_oeb),
        .pad_oeb(pad_oeb)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs and checks happen 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [N-1:0] s0, input logic [N-1:0] s1);
        bus.wr_en   = 1'b1;
        bus.wr_sel0 = s0;
        bus.wr_sel1 = s1;
        tick();
        bus.wr_en = 1'b0;
    endtask

    // Commit, then check a full 2G+1 sequence plus the done cycle.
    task automatic run_seq(input string tag, input logic [N-1:0] frc,
                           input logic [N-1:0] o0, input logic [N-1:0] o1,
                           input logic [N-1:0] n0, input logic [N-1:0] n1);
        bus.commit = 1'b1;
        tick();
        bus.commit = 1'b0;
        bus.wr_en  = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            check($sformatf("%s_busy_c%0d", tag, c), 32'(bus.busy), 32'd1);
            check($sformatf("%s_pad_c%0d", tag, c), 32'(pad_oeb), 32'(frc));
            check($sformatf("%s_sel0_c%0d", tag, c), 32'(sel0),
                  32'((c >= 4) ? n0 : o0));
            check($sformatf("%s_sel1_c%0d", tag, c), 32'(sel1),
                  32'((c >= 4) ? n1 : o1));
            check($sformatf("%s_done_c%0d", tag, c), 32'(bus.done), 32'd0);
            tick();
        end
        check({tag, "_done"}, 32'(bus.done), 32'd1);
        check({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
        check({tag, "_pad_end"}, 32'(pad_oeb), 32'(mux_oeb));
        tick();
        check({tag, "_done_off"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_sel0 = '0;
        bus.wr_sel1 = '0;
        bus.commit  = 1'b0;
        mux_oeb     = '0;
        #12;
        rst_n = 1'b1;
        tick();

        check("rst_sel0", 32'(sel0), 32'd0);
        check("rst_sel1", 32'(sel1), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_pad", 32'(pad_oeb), 32'd0);

        // Basic sequence: pins 0,1 change.
        write(4'b0011, 4'b0000);
        run_seq("t1", 4'b0011, 4'b0000, 4'b0000, 4'b0011, 4'b0000);

        // No-change commit: done next cycle, never busy, mux_oeb passes.
        mux_oeb    = 4'b1010;
        bus.commit = 1'b1;
        tick();
        bus.commit = 1'b0;
        check("nc_done", 32'(bus.done), 32'd1);
        check("nc_busy", 32'(bus.busy), 32'd0);
        check("nc_pad", 32'(pad_oeb), 32'b1010);
        tick();
        check("nc_done_off", 32'(bus.done), 32'd0);
        check("nc_busy2", 32'(bus.busy), 32'd0);
        mux_oeb = '0;

        // Commit during busy, plus a write during busy.
        write(4'b0001, 4'b0000);
        bus.commit = 1'b1;
        tick();
        bus.commit = 1'b0;
        ndone = 0;
        for (int c = 1; c <= 8; c++) begin
            if (bus.done) ndone++;
            if (c == 1) begin
                bus.wr_en   = 1'b1;
                bus.wr_sel0 = 4'b0001;
                bus.wr_sel1 = 4'b1000;
            end
            if (c == 2) begin
                bus.wr_en  = 1'b0;
                bus.commit = 1'b1;
            end
            if (c == 3) bus.commit = 1'b0;
            check($sformatf("t4_err_c%0d", c), 32'(bus.err),
                  32'((c == 3) ? 1 : 0));
            check($sformatf("t4_busy_c%0d", c), 32'(bus.busy),
                  32'((c <= 5) ? 1 : 0));
            check($sformatf("t4_pad_c%0d", c), 32'(pad_oeb),
                  32'((c <= 5) ? 4'b0010 : 4'b0000));
            check($sformatf("t4_done_c%0d", c), 32'(bus.done),
                  32'((c == 6) ? 1 : 0));
            tick();
        end
        check("t4_ndone", 32'(ndone), 32'd1);
        check("t4_sel0", 32'(sel0), 32'b0001);
        check("t4_sel1", 32'(sel1), 32'b0000);

        // Staged sel1 write from the busy window is committed now.
        run_seq("t5", 4'b1000, 4'b0001, 4'b0000, 4'b0001, 4'b1000);

        // Same-cycle write and commit.
        bus.wr_en   = 1'b1;
        bus.wr_sel0 = 4'b0101;
        bus.wr_sel1 = 4'b1000;
        run_seq("t6", 4'b0100, 4'b0001, 4'b1000, 4'b0101, 4'b1000);

        // Asynchronous reset in the middle of SETTLE.
        write(4'b1111, 4'b1000);
        mux_oeb    = 4'b0110;
        bus.commit = 1'b1;
        tick();
        bus.commit = 1'b0;
        tick();
        tick();
        tick();
        check("ar_pre_busy", 32'(bus.busy), 32'd1);
        check("ar_pre_sel0", 32'(sel0), 32'b1111);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_sel0", 32'(sel0), 32'd0);
        check("ar_sel1", 32'(sel1), 32'd0);
        check("ar_busy", 32'(bus.busy), 32'd0);
        check("ar_done", 32'(bus.done), 32'd0);
        check("ar_err", 32'(bus.err), 32'd0);
        check("ar_pad", 32'(pad_oeb), 32'b0110);
        #10;
        rst_n = 1'b1;
        tick();

        // Shadow was reset too: a bare commit changes nothing.
        bus.commit = 1'b1;
        tick();
        bus.commit = 1'b0;
        check("ar_nc_done", 32'(bus.done), 32'd1);
        check("ar_nc_busy", 32'(bus.busy), 32'd0);
        check("ar_nc_sel0", 32'(sel0), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
